// File: rtl/pipe_pkg.sv
// Shared definitions for the ARM pipeline stage registers.
// Default field widths per stage boundary, the bubble (NOP) control value,
// and bit offsets so producing and consuming stages pack fields identically.
package pipe_pkg;

  // Default widths per stage boundary
  localparam int unsigned IFID_CTRL_W  = 1;    // branch-taken flag
  localparam int unsigned IFID_DATA_W  = 64;   // PC, instruction
  localparam int unsigned IDEX_CTRL_W  = 14;
  localparam int unsigned IDEX_DATA_W  = 170;
  localparam int unsigned EXMEM_CTRL_W = 3;    // WB_EN, MEM_R_EN, MEM_W_EN
  localparam int unsigned EXMEM_DATA_W = 68;   // ALU result, Val_Rm, Dest
  localparam int unsigned MEMWB_CTRL_W = 2;    // WB_EN, MEM_R_EN
  localparam int unsigned MEMWB_DATA_W = 68;   // ALU result, memory data, Dest

  // A bubble carries no write enables, so all-zero control is a NOP
  localparam logic [IDEX_CTRL_W-1:0] IDEX_CTRL_NOP = '0;

  // ID/EX control-field bit offsets
  localparam int unsigned C_EXE_CMD_LSB = 0;   // 4 bits
  localparam int unsigned C_EXE_CMD_W   = 4;
  localparam int unsigned C_FWD1_LSB    = 4;   // 2 bits, operand 1 forward select
  localparam int unsigned C_FWD2_LSB    = 6;   // 2 bits, operand 2 forward select
  localparam int unsigned C_FWD_W       = 2;
  localparam int unsigned C_S           = 8;
  localparam int unsigned C_B           = 9;
  localparam int unsigned C_MEM_W_EN    = 10;
  localparam int unsigned C_MEM_R_EN    = 11;
  localparam int unsigned C_WB_EN       = 12;
  localparam int unsigned C_IMM         = 13;

  // ID/EX data-field bit offsets
  localparam int unsigned D_PC_LSB      = 0;    // 32 bits
  localparam int unsigned D_VAL_RN_LSB  = 32;   // 32 bits
  localparam int unsigned D_VAL_RM_LSB  = 64;   // 32 bits
  localparam int unsigned D_IMM_LSB     = 96;   // 32 bits, extended immediate
  localparam int unsigned D_SHIFT_LSB   = 128;  // 12 bits, shift operand
  localparam int unsigned D_IMM24_LSB   = 140;  // 24 bits, branch offset
  localparam int unsigned D_DEST_LSB    = 164;  // 4 bits
  localparam int unsigned D_RSVD_LSB    = 168;  // 2 spare bits

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter for performance debug.
// Latency: count updates on the edge after inc is sampled.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stick at the maximum value
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, freeze, flush and perf counters.
// Latency: 1 cycle from accept to out_valid; 1 beat/cycle throughput.
// Backpressure: SKID=1 absorbs one extra beat so in_ready is flop-driven; SKID=0 passes out_ready through.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W     = IDEX_CTRL_W,
  parameter int unsigned       DATA_W     = IDEX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_FLUSH = '0,
  parameter bit                SKID       = 1'b1,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              m_v;
  logic              s_v;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;
  logic              accept;
  logic              rel;

  // Main entry always drives the outputs; freeze and reset only mask valid
  assign out_valid = rst && m_v && !freeze;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign accept    = in_valid && in_ready;
  assign rel       = out_valid && out_ready;

  generate
    if (SKID) begin : g_skid
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      // Ready depends only on the skid flop and stage-wide controls, never on out_ready
      assign in_ready = rst && !s_v && !freeze && !flush;

      // Two-entry FIFO: main refills from skid first, then from the input
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          m_v    <= 1'b0;
          s_v    <= 1'b0;
          m_ctrl <= CTRL_FLUSH;
          m_data <= '0;
          s_ctrl <= '0;
          s_data <= '0;
        end else if (!freeze) begin
          if (rel || !m_v) begin
            if (s_v) begin
              m_ctrl <= s_ctrl;
              m_data <= s_data;
              m_v    <= 1'b1;
              s_v    <= 1'b0;
            end else if (accept) begin
              m_ctrl <= in_ctrl;
              m_data <= in_data;
              m_v    <= 1'b1;
            end else begin
              m_v    <= 1'b0;
            end
          end else if (accept) begin
            s_ctrl <= in_ctrl;
            s_data <= in_data;
            s_v    <= 1'b1;
          end
        end
      end
    end else begin : g_reg
      assign s_v = 1'b0;

      // Single entry can take a new beat in the same cycle it releases
      assign in_ready = rst && (!m_v || out_ready) && !freeze && !flush;

      // Main entry loads on accept and empties on an uncovered release
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          m_v    <= 1'b0;
          m_ctrl <= CTRL_FLUSH;
          m_data <= '0;
        end else if (!freeze) begin
          if (rel || !m_v) begin
            if (accept) begin
              m_ctrl <= in_ctrl;
              m_data <= in_data;
              m_v    <= 1'b1;
            end else begin
              m_v    <= 1'b0;
            end
          end
        end
      end
    end
  endgenerate

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid && !out_ready),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush && (m_v || s_v)),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// against a queue-based reference model (SKID=1); SKID=0 instance with a 2-bit counter.
module tb_pipe_stage_reg;

  localparam int unsigned CW = 14;
  localparam int unsigned DW = 170;
  localparam logic [CW-1:0] FLUSH_C = 14'h1234;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic          a_freeze, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [15:0]   a_stall, a_bubble;

  logic          b_freeze, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_stall, b_bubble;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CTRL_FLUSH(FLUSH_C), .SKID(1'b1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .freeze(a_freeze), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .freeze(b_freeze), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  // Reference model of instance A: an ordered queue holding at most two beats
  beat_t mq[$];
  int    m_stall  = 0;
  int    m_bubble = 0;

  function automatic bit a_exp_rdy();
    return rst && (mq.size() < 2) && !a_freeze && !a_flush;
  endfunction

  function automatic bit a_exp_vld();
    return rst && (mq.size() > 0) && !a_freeze;
  endfunction

  function automatic beat_t rand_beat();
    logic [191:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return r[CW+DW-1:0];
  endfunction

  function automatic beat_t mk_beat(int unsigned v);
    beat_t b;
    b.c = CW'($urandom);
    b.d = DW'(v);
    return b;
  endfunction

  task automatic drive_a(input bit v, input beat_t b);
    a_in_valid = v;
    a_in_ctrl  = b.c;
    a_in_data  = b.d;
  endtask

  // Advance the model by one cycle using the currently driven inputs, then clock
  task automatic step();
    bit acc, rel;
    acc = a_in_valid && a_exp_rdy();
    rel = a_exp_vld() && a_out_ready;
    if (!rst) begin
      mq.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      if (a_exp_vld() && !a_out_ready && m_stall < 65535) m_stall++;
      if (a_flush) begin
        if (mq.size() > 0 && m_bubble < 65535) m_bubble++;
        mq.delete();
      end else if (!a_freeze) begin
        if (rel) void'(mq.pop_front());
        if (acc) mq.push_back(beat_t'({a_in_ctrl, a_in_data}));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive_a(1'b1, rand_beat());
    b_in_valid = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", a_out_valid); end
    step();
    step();
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready2 got %b exp 0", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid2 got %b exp 0", a_out_valid); end
    checks++; if (a_out_ctrl !== FLUSH_C) begin errors++; $display("FAIL reset_out_ctrl got %h exp %h", a_out_ctrl, FLUSH_C); end
    checks++; if (a_out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", a_out_data); end
    checks++; if (a_stall !== 16'd0 || a_bubble !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", a_stall, a_bubble); end
    checks++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_handshake got %b/%b exp 0/0", b_in_ready, b_out_valid); end
    checks++; if (b_out_ctrl !== '0 || b_stall !== 2'd0) begin errors++; $display("FAIL reset_b_state got %h/%0d exp 0/0", b_out_ctrl, b_stall); end
    rst = 1'b1;
    b_in_valid = 1'b0;
    drive_a(1'b0, rand_beat());
    step();
  endtask

  task automatic test_stream();
    a_out_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      drive_a(k <= 8, mk_beat(k));
      #1;
      if (k <= 8) begin
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got %b exp 1", k, a_in_ready); end
      end
      checks++; if (a_out_valid !== (k > 1)) begin errors++; $display("FAIL stream_out_valid k=%0d got %b exp %b", k, a_out_valid, k > 1); end
      if (k > 1) begin
        checks++; if (a_out_data !== DW'(k - 1)) begin errors++; $display("FAIL stream_out_data k=%0d got %h exp %h", k, a_out_data, k - 1); end
      end
      step();
    end
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drained got %b exp 0", a_out_valid); end
    checks++; if (a_stall !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt got %0d exp 0", a_stall); end
  endtask

  task automatic test_backpressure();
    beat_t ba, bb, bc;
    ba = mk_beat(32'hA);
    bb = mk_beat(32'hB);
    bc = mk_beat(32'hC);
    a_out_ready = 1'b0;
    drive_a(1'b1, ba); #1;
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept_a got %b exp 1", a_in_ready); end
    step();
    drive_a(1'b1, bb); #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_accept_b got rdy=%b data=%h exp 1/a", a_in_ready, a_out_data); end
    step();
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, bc); #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_skid_full i=%0d got %b exp 0", i, a_in_ready); end
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_hold_a i=%0d got %b/%h exp 1/a", i, a_out_valid, a_out_data); end
      step();
    end
    #1;
    checks++; if (a_stall !== 16'd4) begin errors++; $display("FAIL bp_stall_cnt got %0d exp 4", a_stall); end
    a_out_ready = 1'b1; #1;
    checks++; if (a_in_ready !== 1'b0 || a_out_data !== DW'(32'hA)) begin errors++; $display("FAIL bp_release_a got rdy=%b data=%h exp 0/a", a_in_ready, a_out_data); end
    step(); #1;
    checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || a_out_data !== DW'(32'hB)) begin errors++; $display("FAIL bp_release_b got %b/%b/%h exp 1/1/b", a_in_ready, a_out_valid, a_out_data); end
    step();
    drive_a(1'b0, bc); #1;
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== DW'(32'hC) || a_out_ctrl !== bc.c) begin errors++; $display("FAIL bp_release_c got %b/%h exp 1/c", a_out_valid, a_out_data); end
    step(); #1;
    checks++; if (a_out_valid !== 1'b0 || a_stall !== 16'd4) begin errors++; $display("FAIL bp_after got vld=%b stall=%0d exp 0/4", a_out_valid, a_stall); end
  endtask

  task automatic test_flush();
    int stall_before;
    a_out_ready = 1'b0;
    drive_a(1'b1, rand_beat()); step();
    drive_a(1'b1, rand_beat()); step();
    stall_before = m_stall;
    drive_a(1'b1, rand_beat());
    a_freeze = 1'b1;
    a_flush  = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle got rdy=%b vld=%b exp 0/0", a_in_ready, a_out_valid); end
    step();
    a_freeze = 1'b0;
    a_flush  = 1'b0;
    drive_a(1'b0, rand_beat());
    #1;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b exp 0", a_out_valid); end
    checks++; if (a_out_ctrl !== FLUSH_C || a_out_data !== '0) begin errors++; $display("FAIL flush_contents got %h/%h exp %h/0", a_out_ctrl, a_out_data, FLUSH_C); end
    checks++; if (a_bubble !== 16'd1) begin errors++; $display("FAIL flush_bubble_cnt got %0d exp 1", a_bubble); end
    checks++; if (a_stall !== 16'(stall_before)) begin errors++; $display("FAIL flush_stall_kept got %0d exp %0d", a_stall, stall_before); end
    a_flush = 1'b1; step();
    a_flush = 1'b0; #1;
    checks++; if (a_bubble !== 16'd1) begin errors++; $display("FAIL flush_empty_bubble got %0d exp 1", a_bubble); end
  endtask

  task automatic test_freeze();
    beat_t cur;
    int    sent = 0;
    int    got  = 0;
    bit    acc, rel;
    cur = rand_beat();
    a_out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      a_freeze = (cyc >= 3 && cyc <= 5);
      drive_a(sent < 6, cur);
      #1;
      checks++; if (a_in_ready !== a_exp_rdy()) begin errors++; $display("FAIL freeze_in_ready cyc=%0d got %b exp %b", cyc, a_in_ready, a_exp_rdy()); end
      checks++; if (a_out_valid !== a_exp_vld()) begin errors++; $display("FAIL freeze_out_valid cyc=%0d got %b exp %b", cyc, a_out_valid, a_exp_vld()); end
      if (mq.size() > 0) begin
        checks++; if (a_out_data !== mq[0].d) begin errors++; $display("FAIL freeze_head cyc=%0d got %h exp %h", cyc, a_out_data, mq[0].d); end
      end
      acc = a_in_valid && a_exp_rdy();
      rel = a_exp_vld() && a_out_ready;
      step();
      if (rel) got++;
      if (acc) begin sent++; cur = rand_beat(); end
    end
    a_freeze = 1'b0;
    checks++; if (got != 6) begin errors++; $display("FAIL freeze_delivered got %0d exp 6", got); end
  endtask

  task automatic test_random();
    beat_t cur;
    cur = rand_beat();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst         = ($urandom_range(99) != 0);
      a_out_ready = ($urandom_range(3) != 0);
      a_freeze    = ($urandom_range(99) < 8);
      a_flush     = ($urandom_range(99) < 3);
      drive_a($urandom_range(9) < 7, cur);
      #1;
      checks++; if (a_in_ready !== a_exp_rdy()) begin errors++; $display("FAIL rand_in_ready cyc=%0d got %b exp %b", cyc, a_in_ready, a_exp_rdy()); end
      checks++; if (a_out_valid !== a_exp_vld()) begin errors++; $display("FAIL rand_out_valid cyc=%0d got %b exp %b", cyc, a_out_valid, a_exp_vld()); end
      if (a_exp_vld()) begin
        checks++; if ({a_out_ctrl, a_out_data} !== mq[0]) begin errors++; $display("FAIL rand_head cyc=%0d got %h exp %h", cyc, {a_out_ctrl, a_out_data}, mq[0]); end
      end
      checks++; if (a_stall !== 16'(m_stall) || a_bubble !== 16'(m_bubble)) begin errors++; $display("FAIL rand_counters cyc=%0d got %0d/%0d exp %0d/%0d", cyc, a_stall, a_bubble, m_stall, m_bubble); end
      if (a_in_valid && a_exp_rdy()) begin
        step();
        cur = rand_beat();
      end else begin
        step();
      end
    end
    rst = 1'b1;
    a_freeze = 1'b0;
    a_flush  = 1'b0;
    drive_a(1'b0, cur);
    a_out_ready = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_skid0();
    beat_t p, q, r;
    p = mk_beat(32'h50);
    q = mk_beat(32'h51);
    r = mk_beat(32'h52);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_ctrl = p.c; b_in_data = p.d; #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL b_empty_ready got %b exp 1", b_in_ready); end
    step();
    b_in_ctrl = q.c; b_in_data = q.d;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1 || b_out_data !== p.d) begin errors++; $display("FAIL b_stall i=%0d got %b/%b/%h exp 0/1/%h", i, b_in_ready, b_out_valid, b_out_data, p.d); end
      step();
    end
    #1;
    checks++; if (b_stall !== 2'd3) begin errors++; $display("FAIL b_stall_sat got %0d exp 3", b_stall); end
    b_out_ready = 1'b1; #1;
    checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL b_ready_follows got %b exp 1", b_in_ready); end
    step();
    b_in_ctrl = r.c; b_in_data = r.d; #1;
    checks++; if (b_in_ready !== 1'b1 || b_out_data !== q.d || b_out_ctrl !== q.c) begin errors++; $display("FAIL b_stream_q got %b/%h exp 1/%h", b_in_ready, b_out_data, q.d); end
    step();
    b_in_valid = 1'b0; #1;
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== r.d) begin errors++; $display("FAIL b_stream_r got %b/%h exp 1/%h", b_out_valid, b_out_data, r.d); end
    step(); #1;
    checks++; if (b_out_valid !== 1'b0 || b_stall !== 2'd3) begin errors++; $display("FAIL b_after got %b/%0d exp 0/3", b_out_valid, b_stall); end
  endtask

  initial begin
    rst = 1'b0;
    a_freeze = 1'b0; a_flush = 1'b0; a_out_ready = 1'b0;
    a_in_valid = 1'b0; a_in_ctrl = '0; a_in_data = '0;
    b_freeze = 1'b0; b_flush = 1'b0; b_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_freeze();
    test_random();
    test_skid0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the ARM pipeline, successor to the fixed-field ID/EX register. It carries an opaque control field and data field between two stages with a valid/ready handshake, an optional 2-entry skid buffer so `in_ready` is registered, stage-wide freeze and flush, and saturating stall/bubble counters for performance debug. One instance per stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).

## Interface
- `CTRL_W`, 14: control field width (WB_EN, MEM_R/W_EN, B, S, forwarding selects, EXE_CMD); the only field loaded with `CTRL_FLUSH` on flush.
- `DATA_W`, 170: data field width (PC, Val_Rn, Val_Rm, imm, shift operand, imm24, Dest); cleared to 0 on flush.
- `CTRL_FLUSH`, `{CTRL_W{1'b0}}`: control value for a bubble (NOP).
- `SKID`, 1: 1 = 2-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- `CNT_W`, 16: counter width.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset. Synchronous, active-low.
- `freeze` in 1: hold the whole stage.
- `flush` in 1: squash the stage contents.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: stage accepts a beat this cycle.
- `in_ctrl` in CTRL_W, `in_data` in DATA_W: upstream beat.
- `out_valid` out 1: beat available downstream.
- `out_ready` in 1: downstream accepts.
- `out_ctrl` out CTRL_W, `out_data` out DATA_W: head beat.
- `stall_cnt` out CNT_W: cycles with `out_valid && !out_ready`, saturating.
- `bubble_cnt` out CNT_W: flush events that discarded at least one valid beat, saturating.

## Operation
- Storage: main entry (`m_v`, `m_ctrl`, `m_data`) drives the outputs. With SKID=1, a skid entry (`s_v`, `s_ctrl`, `s_data`) also exists.
- Accept: `in_valid && in_ready`. Release: `out_valid && out_ready`.
- `out_valid = m_v && !freeze`. `out_ctrl`/`out_data` always reflect the main entry.
- SKID=1: `in_ready = !s_v && !freeze && !flush`. Both registered-state terms come from flops.
  - Accept while main is empty, or main releases: load main.
  - Accept while main is held: load skid.
  - Main releases with skid full: skid moves to main and skid empties.
  - Order is strictly FIFO. No beat is lost or duplicated.
- SKID=0: `in_ready = (!m_v || out_ready) && !freeze && !flush`. The skid entry is absent.
- Priority, highest first: reset, flush, freeze, normal.
  - Flush wins over freeze, unlike the legacy register.
- Flush cycle:
  - `m_v`, `s_v` <= 0; `m_ctrl` <= CTRL_FLUSH; `m_data` <= 0; skid fields <= 0.
  - `in_ready` = 0, so the upstream beat is not accepted and upstream must re-present or squash it.
  - `out_valid` may be 1 during the flush cycle; a release in that cycle completes normally.
- Freeze cycle (no flush): no entry changes; `in_ready` = 0; `out_valid` = 0.
- Counters:
  - `stall_cnt` +1 when `out_valid && !out_ready` (freeze cycles do not count).
  - `bubble_cnt` +1 in a flush cycle with `m_v || s_v`.
  - Both hold at `2^CNT_W-1`. Counters keep running during freeze; flush does not clear them.
- Reset (`rst`=0 at edge):
  - `m_v`, `s_v` = 0; `m_ctrl` = CTRL_FLUSH; `m_data` = 0; counters = 0.
  - While in reset, `in_ready` = 0 and `out_valid` = 0. Reset mid-transfer discards all contents.

## Timing
- Latency: a beat accepted at edge N is on `out_*` with `out_valid` = 1 after edge N; it can be released in cycle N+1.
- Throughput: 1 beat/cycle when `out_ready` is held high, for both SKID values.
- SKID=1 `in_ready` has no combinational path from `out_ready`. It falls one cycle after the skid fills and rises one cycle after the skid drains.
- SKID=0 has a combinational `out_ready`→`in_ready` path.
- Flush and freeze are sampled at the same edge as the data they act on.

## Structure
- Package `pipe_pkg`:
  - Default `CTRL_W`/`DATA_W` per stage boundary.
  - `CTRL_FLUSH` NOP constant.
  - Control-field bit offsets (WB_EN, MEM_R_EN, MEM_W_EN, B, S, fwd selects, EXE_CMD) and data-field offsets, so stages pack and unpack consistently.
- Sub-module `sat_counter` (CNT_W, `clk`, `rst`, `inc`, `cnt`), instantiated twice.
- Skid logic stays inline under `generate if (SKID)`.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `in_valid`=1 -> `out_valid`=0, `in_ready`=0, `out_ctrl`=CTRL_FLUSH, `out_data`=0, counters 0.
- Streaming, SKID=1: 8 beats with data 0x1..0x8, `out_ready`=1 -> outputs 0x1..0x8 in consecutive cycles, one cycle after each accept; `stall_cnt`=0.
- Back-pressure, SKID=1: `out_ready`=0 for 4 cycles during a stream of 0xA, 0xB, 0xC -> 0xA held in main, 0xB in skid, `in_ready`=0 from the next cycle, 0xC not accepted, `stall_cnt`=4; after release, order is 0xA, 0xB, 0xC.
- Flush with both entries full and `freeze`=1 -> next cycle `out_valid`=0, `out_ctrl`=CTRL_FLUSH, `out_data`=0, `bubble_cnt`=1. A flush of an empty stage leaves `bubble_cnt` unchanged.
- Freeze 3 cycles mid-stream -> `out_valid`=0 and `in_ready`=0 throughout, contents unchanged, stream resumes without loss.
- SKID=0, CNT_W=2: 5 stall cycles -> `stall_cnt` saturates at 3; `in_ready` follows `out_ready` in the same cycle while full.
